// File: rtl/if_fetch_pkg.sv
// Shared widths, FSM encoding and small helpers for the instruction-fetch front end.
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int STALL_W     = 6;

  typedef enum logic {
    IF_IDLE = 1'b0,
    IF_FILL = 1'b1
  } if_state_e;

  function automatic logic [INST_ADDR_W-1:0] next_pc(input logic [INST_ADDR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache: combinational read,
// synchronous write, valid bits cleared by the asynchronous reset.
module icache_dm
  import if_fetch_pkg::*;
#(
  parameter int INDEX_W = 7,
  parameter int TAG_W   = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               hit,
  output logic [INST_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [INST_W-1:0]  wr_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [INST_W-1:0] data_mem [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bit qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign hit     = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: PC register, I-cache lookup, and a byte-serial
// miss fill over the memory controller's 8-bit port.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          INDEX_W  = 7,
  parameter int          ADDR_W   = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic [STALL_W-1:0]     stall,
  input  logic                   br,
  input  logic [INST_ADDR_W-1:0] br_addr,
  input  logic                   mem_grant,
  input  logic [7:0]             mem_rdata,
  output logic                   mem_req,
  output logic [INST_ADDR_W-1:0] mem_addr,
  output logic [INST_ADDR_W-1:0] if_pc,
  output logic [INST_ADDR_W-1:0] if_npc,
  output logic [INST_W-1:0]      if_inst,
  output logic                   stallreq_if
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  if_state_e              state, state_nxt;
  logic [INST_ADDR_W-1:0] pc;
  logic [1:0]             cnt;
  logic                   issue_done;
  logic                   pend;
  logic [1:0]             pend_k;
  logic                   drop;
  logic [23:0]            word_lo;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic [INST_W-1:0]  line_data;
  logic               grant;
  logic               byte_ok;
  logic               fill_done;

  logic unused_bits;
  assign unused_bits = ^{stall[STALL_W-1:1], br_addr[1:0], pc[INST_ADDR_W-1:ADDR_W]};

  assign idx = pc[INDEX_W+1:2];
  assign tag = pc[ADDR_W-1:INDEX_W+2];

  icache_dm #(
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_icache (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (idx),
    .rd_tag (tag),
    .hit    (hit),
    .rd_data(line_data),
    .wr_en  (fill_done),
    .wr_idx (idx),
    .wr_tag (tag),
    .wr_data({mem_rdata, word_lo})
  );

  assign mem_req     = (state == IF_FILL) && !issue_done;
  assign mem_addr    = {pc[INST_ADDR_W-1:2], cnt};
  assign grant       = mem_req && mem_grant;
  // A returned byte belongs to the current fill only if no redirect cut it off.
  assign byte_ok     = pend && !drop;
  assign fill_done   = rdy && byte_ok && !br && (pend_k == 2'd3);

  assign if_pc       = pc;
  assign if_npc      = next_pc(pc);
  assign if_inst     = hit ? line_data : '0;
  assign stallreq_if = !(hit && (state == IF_IDLE));

  always_comb begin
    state_nxt = state;
    case (state)
      IF_IDLE: if (!hit) state_nxt = IF_FILL;
      IF_FILL: if (fill_done) state_nxt = IF_IDLE;
      default: state_nxt = IF_IDLE;
    endcase
    if (br) state_nxt = IF_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IF_IDLE;
      pc         <= RESET_PC;
      cnt        <= 2'd0;
      issue_done <= 1'b0;
      pend       <= 1'b0;
      pend_k     <= 2'd0;
      drop       <= 1'b0;
    end else if (rdy) begin
      state <= state_nxt;
      if (br) begin
        pc         <= {br_addr[INST_ADDR_W-1:2], 2'b00};
        cnt        <= 2'd0;
        issue_done <= 1'b0;
        pend       <= 1'b0;
        drop       <= grant;
      end else begin
        drop <= 1'b0;
        pend <= grant;
        if (grant) begin
          pend_k <= cnt;
          cnt    <= cnt + 2'd1;
          if (cnt == 2'd3) issue_done <= 1'b1;
        end
        if (fill_done) issue_done <= 1'b0;
        if ((state == IF_IDLE) && hit && !stall[0]) pc <= next_pc(pc);
        if ((state == IF_IDLE) && !hit) begin
          cnt        <= 2'd0;
          issue_done <= 1'b0;
        end
      end
    end
  end

  // Byte assembler: lanes 0..2 are staged here, lane 3 goes straight to the cache.
  always_ff @(posedge clk) begin
    if (rdy && byte_ok && !br) begin
      case (pend_k)
        2'd0:    word_lo[7:0]   <= mem_rdata;
        2'd1:    word_lo[15:8]  <= mem_rdata;
        2'd2:    word_lo[23:16] <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch with a byte-serial memory controller model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst, rdy, br, mem_grant;
  logic [STALL_W-1:0]     stall;
  logic [INST_ADDR_W-1:0] br_addr;
  logic [7:0]             mem_rdata;
  logic                   mem_req, stallreq_if;
  logic [INST_ADDR_W-1:0] mem_addr, if_pc, if_npc;
  logic [INST_W-1:0]      if_inst;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0), .INDEX_W(7), .ADDR_W(18)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall), .br(br), .br_addr(br_addr),
    .mem_grant(mem_grant), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_addr(mem_addr),
    .if_pc(if_pc), .if_npc(if_npc), .if_inst(if_inst), .stallreq_if(stallreq_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0) return 32'h0000_0013;
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] sh;
    sh = mem_word(a) >> {a[1:0], 3'b000};
    return sh[7:0];
  endfunction

  // Controller model: data for a granted address appears the following cycle
  // and is held while rdy is low.
  logic        gap_arm  = 1'b0;
  int          gap_left = 0;
  logic        m_g;
  logic [31:0] m_a;

  initial begin
    mem_grant = 1'b1;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      m_g = rst && rdy && mem_req && mem_grant;
      m_a = mem_addr;
      @(posedge clk);
      #1;
      if (m_g) mem_rdata = mem_byte(m_a);
      if (gap_left > 0) gap_left--;
      if (m_g && (m_a[1:0] == 2'd0) && gap_arm) begin
        gap_left = 2;
        gap_arm  = 1'b0;
      end
      mem_grant = (gap_left == 0);
    end
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] watch_addr;
  int          watch_cnt, grant_cnt;
  logic        first_seen;
  logic [31:0] first_addr;

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = mem_word(pc);
    sb.push_back(e);
  endtask

  task automatic reset_watch(input logic [31:0] a);
    watch_addr = a;
    watch_cnt  = 0;
    grant_cnt  = 0;
    first_seen = 1'b0;
    first_addr = 32'hFFFF_FFFF;
  endtask

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (mem_req && (mem_addr == watch_addr)) watch_cnt++;
    if (rst && rdy && mem_req && mem_grant) grant_cnt++;
    if (mem_req && !first_seen) begin
      first_seen = 1'b1;
      first_addr = mem_addr;
    end
    if (rst && rdy && !br && !stall[0] && !stallreq_if) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_fetch", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", if_pc, e.pc);
        chk("sb_npc", if_npc, e.pc + 32'd4);
        chk("sb_inst", if_inst, e.inst);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_present(input int max, output int n);
    n = 0;
    while (stallreq_if && (n < max)) begin
      cyc();
      n++;
    end
    if (stallreq_if) chk("wait_timeout", 32'(stallreq_if), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; rdy = 1'b1; br = 1'b0; br_addr = '0; stall = '0;
    reset_watch(32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_stallreq", 32'(stallreq_if), 32'd1);
    chk("rst_if_inst", if_inst, 32'h0);

    rst = 1'b1;
    cyc();
    chk("rel_mem_req", 32'(mem_req), 32'd1);
    chk("rel_mem_addr", mem_addr, 32'h0);
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_if_pc", if_pc, 32'h0);
    chk("midrst_stallreq", 32'(stallreq_if), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;

    // Cold miss at 0x0
    push(32'h0);
    wait_present(30, n);
    chk("cold_penalty", 32'(n), 32'd6);
    chk("cold_inst", if_inst, 32'h0000_0013);
    cyc();
    chk("adv_pc", if_pc, 32'h4);
    chk("adv_miss", 32'(stallreq_if), 32'd1);

    // Fill of 0x4 with a two-cycle grant gap
    gap_arm = 1'b1;
    reset_watch(32'h5);
    push(32'h4);
    wait_present(30, n);
    chk("gap_penalty", 32'(n), 32'd8);
    chk("gap_addr_hold", 32'(watch_cnt), 32'd3);
    cyc();

    // Redirect to 0x100 after two bytes of 0x8
    cyc();
    chk("fill8_addr0", mem_addr, 32'h8);
    cyc();
    cyc();
    chk("fill8_addr2", mem_addr, 32'hA);
    br = 1'b1; br_addr = 32'h103;
    cyc();
    br = 1'b0;
    chk("br_pc", if_pc, 32'h100);
    chk("br_idle_req", 32'(mem_req), 32'd0);
    reset_watch(32'hFFFF_FFFF);
    push(32'h100);
    wait_present(30, n);
    chk("br_penalty", 32'(n), 32'd6);
    chk("br_first_addr", first_addr, 32'h100);
    cyc();

    // Redirect back to 0x8 misses; abort it with byte 3 in flight
    br = 1'b1; br_addr = 32'h8;
    cyc();
    br = 1'b0;
    chk("br8_miss", 32'(stallreq_if), 32'd1);
    cyc();
    chk("br8_req", 32'(mem_req), 32'd1);
    chk("br8_addr", mem_addr, 32'h8);
    cyc(); cyc(); cyc();
    chk("br8_addr3", mem_addr, 32'hB);
    br = 1'b1; br_addr = 32'h0;
    cyc();
    br = 1'b0;
    chk("br0_hit", 32'(stallreq_if), 32'd0);

    // Hit held by stall[0]
    stall = 6'b000001;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stl_pc", if_pc, 32'h0);
      chk("stl_mem_req", 32'(mem_req), 32'd0);
      chk("stl_stallreq", 32'(stallreq_if), 32'd0);
      chk("stl_inst", if_inst, 32'h0000_0013);
    end
    stall = '0;
    push(32'h0);
    cyc();
    chk("stl_rel_pc", if_pc, 32'h4);
    chk("hit4", 32'(stallreq_if), 32'd0);
    push(32'h4);
    cyc();

    // Alias: 0x200 shares index 0 with 0x0
    br = 1'b1; br_addr = 32'h200;
    cyc();
    br = 1'b0;
    push(32'h200);
    wait_present(30, n);
    chk("alias_penalty", 32'(n), 32'd6);
    cyc();
    br = 1'b1; br_addr = 32'h0;
    cyc();
    br = 1'b0;
    chk("alias_miss", 32'(stallreq_if), 32'd1);
    reset_watch(32'hFFFF_FFFF);
    push(32'h0);
    wait_present(30, n);
    chk("alias_refill_pen", 32'(n), 32'd6);
    chk("alias_bytes", 32'(grant_cnt), 32'd4);
    cyc();

    // rdy freeze with a byte return outstanding
    br = 1'b1; br_addr = 32'h40;
    cyc();
    br = 1'b0;
    cyc(); cyc(); cyc();
    chk("frz_addr_pre", mem_addr, 32'h42);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("frz_mem_req", 32'(mem_req), 32'd1);
      chk("frz_mem_addr", mem_addr, 32'h42);
    end
    rdy = 1'b1;
    push(32'h40);
    wait_present(30, n);
    chk("frz_remaining", 32'(n), 32'd3);
    cyc();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
